cms_trace_fifo: RTL

CMS_TRACE_FIFO -- requirements
Module: cms_trace_fifo

---
 rtl/cms_trace_fifo_if.sv | 12 +
 rtl/cms_trace_fifo.sv | 82 ++++++++
 2 files changed

// File: rtl/cms_trace_fifo_if.sv
// rtl/cms_trace_fifo_if.sv - trace packet stream bundle (tdata/tvalid/tready/tlast)
interface cms_trace_fifo_if #(
   parameter int DATA_WIDTH = 96
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/cms_trace_fifo.sv
// rtl/cms_trace_fifo.sv - first-word fall-through trace FIFO between monitor and DMA
// Each entry holds {tlast, tdata}. Occupancy and high-water mark are reported alongside.
module cms_trace_fifo #(
   parameter int DATA_WIDTH = 96,
   parameter int DEPTH      = 16,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   cms_trace_fifo_if.slave      S_AXIS,
   cms_trace_fifo_if.master     M_AXIS,
   input  logic                 flush,
   output logic [AW:0]          level,
   output logic [AW:0]          high_water,
   output logic                 full
);

   logic [DATA_WIDTH:0] mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [AW:0]         level_nxt;
   logic                push;
   logic                pop;
   logic [DATA_WIDTH:0] head;

   // Ready is a function of occupancy only, so a same-cycle pop never frees a slot.
   assign full          = (level == DEPTH[AW:0]);
   assign S_AXIS.tready = !full && !rst;
   assign M_AXIS.tvalid = (level != '0);

   assign push = S_AXIS.tvalid && S_AXIS.tready;
   assign pop  = M_AXIS.tvalid && M_AXIS.tready;

   assign head          = mem[rd_ptr];
   assign M_AXIS.tdata  = head[DATA_WIDTH-1:0];
   assign M_AXIS.tlast  = head[DATA_WIDTH];

   always_comb begin
      level_nxt = level;
      if (flush) begin
         level_nxt = '0;
      end else if (push && !pop) begin
         level_nxt = level + 1'b1;
      end else if (pop && !push) begin
         level_nxt = level - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         high_water <= '0;
      end else begin
         level <= level_nxt;
         if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            high_water <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            if (level_nxt > high_water) begin
               high_water <= level_nxt;
            end
         end
      end
   end

   // Storage is never reset; entries are only meaningful below level.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= {S_AXIS.tlast, S_AXIS.tdata};
      end
   end

endmodule
